// File: rtl/register_file_mp.sv
// ============================================================================
// register_file_mp
// ----------------------------------------------------------------------------
// Parametrised multi-port integer register file for the pipelined core, with a
// per-register write-pending (busy) scoreboard for the hazard unit.
//
// Register 0 is hardwired to zero: it is never written, always reads 0 and its
// busy bit is never set. When several write ports target the same register in
// one cycle, the lowest-index port wins and the others are dropped. Reads are
// combinational; with BYPASS=1 a same-cycle winning write is forwarded to the
// read data (the busy bit is not affected by forwarding).
//
// Parameters:
//   XLEN    data width in bits
//   NREGS   number of architectural registers (power of two, >= 2)
//   NREAD   number of read ports
//   NWRITE  number of write ports (port 0 = Execute, highest priority)
//   BYPASS  1 = forward same-cycle write data to read ports, 0 = stored value
//   AW      address width (derived from NREGS)
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   reset     asynchronous, active-low reset (clears registers and busy bits)
//   RA        packed read addresses, port i at [i*AW +: AW]
//   RD        packed read data, port i at [i*XLEN +: XLEN]
//   RBusy     busy bit of the register addressed by read port i
//   WE        write enables, one per write port
//   WA        packed write addresses, port j at [j*AW +: AW]
//   WD        packed write data, port j at [j*XLEN +: XLEN]
//   BusySet   mark register BusyAddr as pending at the next edge
//   BusyAddr  register to mark busy
//   AnyBusy   OR of all busy bits
// ============================================================================
module register_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     RA,
    output logic [NREAD*XLEN-1:0]   RD,
    output logic [NREAD-1:0]        RBusy,
    input  logic [NWRITE-1:0]       WE,
    input  logic [NWRITE*AW-1:0]    WA,
    input  logic [NWRITE*XLEN-1:0]  WD,
    input  logic                    BusySet,
    input  logic [AW-1:0]           BusyAddr,
    output logic                    AnyBusy
);

    // ------------------------------------------------------------------------
    // Write arbitration: a port commits only if it is enabled, targets a
    // non-zero register, and no lower-index enabled port targets the same
    // register. At most one port wins per address, so consumers of win[] may
    // scan the ports in any order.
    // ------------------------------------------------------------------------
    logic [NWRITE-1:0] win;

    always_comb begin
        win = '0;
        for (int j = 0; j < NWRITE; j++) begin
            win[j] = WE[j] && (WA[j*AW +: AW] != '0);
            for (int k = 0; k < j; k++) begin
                if (WE[k] && (WA[k*AW +: AW] == WA[j*AW +: AW])) begin
                    win[j] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register storage and busy scoreboard, one slice per register.
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]  reg_view [NREGS];
    logic [NREGS-1:0] busy_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // Hardwired zero: no storage, never busy.
                assign reg_view[gi] = '0;
                assign busy_vec[gi] = 1'b0;
            end else begin : g_store
                logic [XLEN-1:0] data_reg;
                logic [XLEN-1:0] data_next;
                logic            busy_reg;
                logic            busy_next;
                logic            wr_hit;
                logic            set_hit;

                always_comb begin
                    wr_hit    = 1'b0;
                    data_next = data_reg;
                    for (int j = 0; j < NWRITE; j++) begin
                        if (win[j] && (WA[j*AW +: AW] == AW'(gi))) begin
                            wr_hit    = 1'b1;
                            data_next = WD[j*XLEN +: XLEN];
                        end
                    end
                end

                // A committed write retires the pending producer; a new issue
                // in the same cycle takes precedence and keeps it busy.
                assign set_hit   = BusySet && (BusyAddr == AW'(gi));
                assign busy_next = set_hit | (busy_reg & ~wr_hit);

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        data_reg <= '0;
                        busy_reg <= 1'b0;
                    end else begin
                        data_reg <= data_next;
                        busy_reg <= busy_next;
                    end
                end

                assign reg_view[gi] = data_reg;
                assign busy_vec[gi] = busy_reg;
            end
        end
    endgenerate

    assign AnyBusy = |busy_vec;

    // ------------------------------------------------------------------------
    // Read ports: combinational, with optional forwarding of the winning
    // same-cycle write. Forwarding is suppressed while reset is low so that
    // read data is zero throughout reset.
    // ------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] stored;
            logic [XLEN-1:0] fwd;
            logic            fwd_hit;

            assign ra     = RA[gi*AW +: AW];
            assign stored = reg_view[ra];

            // win[] already excludes address 0, so register 0 is never
            // forwarded and keeps reading zero.
            always_comb begin
                fwd_hit = 1'b0;
                fwd     = '0;
                for (int j = 0; j < NWRITE; j++) begin
                    if (win[j] && (WA[j*AW +: AW] == ra)) begin
                        fwd_hit = 1'b1;
                        fwd     = WD[j*XLEN +: XLEN];
                    end
                end
            end

            assign RD[gi*XLEN +: XLEN] = ((BYPASS != 0) && reset && fwd_hit) ? fwd : stored;
            assign RBusy[gi]           = busy_vec[ra];
        end
    endgenerate

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port integer register file with a write-pending scoreboard for the pipelined core.
- Replaces the fixed 2R/2W, 32x32 register file.
- Generalised in width, depth and read/write port count; optional write-to-read bypass.
- Per-register busy bits give the hazard unit the pending-write status of each read operand.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >= 2)
NREAD, 2, number of read ports
NWRITE, 2, number of write ports; port 0 = Execute, highest priority
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value
AW, $clog2(NREGS), address width (derived)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
RA  in  NREAD*AW  packed read addresses, port i at [i*AW +: AW]
RD  out  NREAD*XLEN  packed read data, port i at [i*XLEN +: XLEN]
RBusy  out  NREAD  busy bit of the register addressed by RA port i
WE  in  NWRITE  write enables
WA  in  NWRITE*AW  packed write addresses
WD  in  NWRITE*XLEN  packed write data
BusySet  in  1  mark register BusyAddr as pending (issue of a producing instruction)
BusyAddr  in  AW  register to mark busy
AnyBusy  out  1  OR of all busy bits

Behaviour:
- Reset (reset=0, asynchronous): all registers cleared to 0 and all busy bits cleared.
  - Consequence: RD=0, RBusy=0 and AnyBusy=0 while reset is low.
  - Reset asserted mid-operation discards pending writes and BusySet that cycle.
- Register 0 is hardwired zero:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0, including when bypassed.
  - Busy bit 0 is never set.
- Writes:
  - Register updates at the rising edge when WE[j]=1.
  - One-cycle write latency.
- Write conflicts: several enabled write ports targeting the same address in one cycle.
  - The lowest-index port wins; higher ports to that address are dropped.
  - Writes to different addresses in the same cycle all commit.
- Reads are combinational, zero latency.
  - BYPASS=1: if any enabled write port targets RA[i] (non-zero) this cycle, RD[i] returns the winning port's WD (same priority rule).
  - BYPASS=0: RD[i] returns the stored value; the new value is visible the cycle after the edge.
- Scoreboard:
  - BusySet=1 sets busy[BusyAddr] at the edge.
  - Any committed write (winning port, WE=1, non-zero address) clears busy[WA] at the edge.
  - Set and clear of the same register in the same cycle: set wins, so the register stays busy (a new producer has issued).
  - RBusy[i] = busy[RA[i]]. It reflects registered state only; bypass does not clear it combinationally.
- Out-of-range addresses cannot occur (NREGS is a power of two), so no wrap handling is needed.
- All outputs are fully defined for every input combination; no X propagation from uninitialised state.

Test Plan:
1. Reset then read: reset low 10ns, then high; read RA0=1, RA1=31 -> RD=0x00000000 on both; AnyBusy=0.
2. Single write and BYPASS=1 forwarding: WE0=1, WA0=1, WD0=0xAAAAAAAA with RA0=1.
   - Same cycle: RD0=0xAAAAAAAA.
   - After the edge with WE0=0: RD0 still reads 0xAAAAAAAA.
   - Repeat with BYPASS=0: RD0=0 in the write cycle, 0xAAAAAAAA after.
3. Write conflict: WE0=WE1=1, WA0=WA1=2, WD0=0xA00AA00A, WD1=0xBBBBBBBB -> after the edge reg2 reads 0xA00AA00A.
4. Dual independent writes: WA0=3/WD0=0x11111111, WA1=4/WD1=0x22222222 -> after the edge RA0=3 reads 0x11111111 and RA1=4 reads 0x22222222.
5. Register 0 protection: WE1=1, WA1=0, WD1=0xFFFFFFFF; BusySet with BusyAddr=0 -> RD at address 0 = 0 in the same and next cycle; RBusy=0.
6. Scoreboard: BusySet, BusyAddr=5.
   - Next cycle: RBusy=1 for RA=5 and AnyBusy=1.
   - Then WE1=1, WA1=5 together with BusySet, BusyAddr=5: reg5 stays busy.
   - Then WE0=1, WA0=5 alone: busy clears, AnyBusy=0.
   - Assert reset with reg7 busy: busy clears immediately, without waiting for a clock edge.
